// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, req/ack memory port, one-deep output buffer
module fetch_ctrl #(
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [15:0]       fetch_cnt,
  output logic              err,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, ERR = 2'd3} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              pend;
  logic [ADDR_W-1:0] pend_pc;
  logic [7:0]        tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_pc   <= '0;
      tmo       <= '0;
      ins_data  <= '0;
      ins_pc    <= '0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= redirect_pc;
          if (run) begin
            state <= REQ;
            tmo   <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (redirect || pend) begin
              // stale word: drop it and re-issue at the newest redirect target
              pc   <= redirect ? redirect_pc : pend_pc;
              pend <= 1'b0;
              tmo  <= '0;
            end else begin
              ins_data <= mem_rdata;
              ins_pc   <= pc;
              pc       <= pc + 1'b1;
              state    <= HOLD;
            end
          end else begin
            // outstanding request is never abandoned, so the redirect waits for its ack
            if (redirect) begin
              pend    <= 1'b1;
              pend_pc <= redirect_pc;
            end
            if (tmo == TMO_LAST) state <= ERR;
            else                 tmo   <= tmo + 8'd1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= run ? REQ : IDLE;
            tmo   <= '0;
          end else if (ins_ready) begin
            fetch_cnt <= fetch_cnt + 16'd1;
            state     <= run ? REQ : IDLE;
            tmo       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == REQ);
  assign ins_valid = (state == HOLD);
  assign err       = (state == ERR);
  assign mem_addr  = pc;
  assign state_o   = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl with a wait-state memory model
module tb_fetch_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          ins_ready = 1'b0;
  logic          mem_req, mem_ack, ins_valid, err;
  logic [AW-1:0] mem_addr, ins_pc;
  logic [DW-1:0] mem_rdata, ins_data;
  logic [15:0]   fetch_cnt;
  logic [1:0]    state_o;

  logic          run2 = 1'b0;
  logic          mem_req2, mem_ack2, ins_valid2, err2;
  logic [AW-1:0] mem_addr2, ins_pc2;
  logic [DW-1:0] mem_rdata2, ins_data2;
  logic [15:0]   fetch_cnt2;
  logic [1:0]    state_o2;

  int   ws = 0;
  logic ack_en = 1'b1;
  int   wcnt;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // memory: word i holds i+0x100, acks after ws wait cycles
  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign mem_ack    = mem_req && ack_en && (wcnt == ws);
  assign mem_rdata  = {20'b0, mem_addr} + 32'h100;
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = {20'b0, mem_addr2} + 32'h100;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'h000), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset(reset), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_pc(ins_pc),
    .fetch_cnt(fetch_cnt), .err(err), .state_o(state_o)
  );

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'hFFE), .TIMEOUT(TMO)) u_dut2 (
    .clk(clk), .reset(reset), .run(run2), .redirect(1'b0), .redirect_pc(12'h000),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .ins_valid(ins_valid2), .ins_ready(1'b1), .ins_data(ins_data2), .ins_pc(ins_pc2),
    .fetch_cnt(fetch_cnt2), .err(err2), .state_o(state_o2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          run;
    logic          redirect;
    logic [AW-1:0] rpc;
    logic          ready;
    logic [1:0]    st;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] ipc;
    logic [15:0]   cnt;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int reqs, guard, n, got;
    logic [AW-1:0] pcs[3];

    vecs[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd1, 12'h000, 32'h000, 12'h000, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd2, 12'h001, 32'h100, 12'h000, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd1, 12'h001, 32'h100, 12'h000, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd2, 12'h002, 32'h101, 12'h001, 16'd1};
    vecs[4]  = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd1, 12'h002, 32'h101, 12'h001, 16'd2};
    vecs[5]  = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd2, 12'h003, 32'h102, 12'h002, 16'd2};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 2'd0, 12'h003, 32'h102, 12'h002, 16'd3};
    vecs[7]  = '{1'b1, 1'b0, 12'h000, 1'b0, 2'd1, 12'h003, 32'h102, 12'h002, 16'd3};
    vecs[8]  = '{1'b1, 1'b0, 12'h000, 1'b0, 2'd2, 12'h004, 32'h103, 12'h003, 16'd3};
    vecs[9]  = '{1'b1, 1'b0, 12'h000, 1'b0, 2'd2, 12'h004, 32'h103, 12'h003, 16'd3};
    vecs[10] = '{1'b1, 1'b1, 12'h050, 1'b1, 2'd1, 12'h050, 32'h103, 12'h003, 16'd3};
    vecs[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 2'd2, 12'h051, 32'h150, 12'h050, 16'd3};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 1'b1, 2'd0, 12'h051, 32'h150, 12'h050, 16'd4};
    vecs[13] = '{1'b0, 1'b1, 12'h7FF, 1'b0, 2'd0, 12'h7FF, 32'h150, 12'h050, 16'd4};
    vecs[14] = '{1'b1, 1'b0, 12'h000, 1'b0, 2'd1, 12'h7FF, 32'h150, 12'h050, 16'd4};
    vecs[15] = '{1'b1, 1'b0, 12'h000, 1'b0, 2'd2, 12'h800, 32'h8FF, 12'h7FF, 16'd4};
    vecs[16] = '{1'b0, 1'b0, 12'h000, 1'b1, 2'd0, 12'h800, 32'h8FF, 12'h7FF, 16'd5};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h000);
    chk("rst_ins_data", ins_data, 32'h0);
    chk("rst_ins_pc", 32'(ins_pc), 32'h0);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pc2", 32'(mem_addr2), 32'hFFE);

    for (int i = 0; i < 17; i++) begin
      run = vecs[i].run; redirect = vecs[i].redirect;
      redirect_pc = vecs[i].rpc; ins_ready = vecs[i].ready;
      tick();
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vecs[i].st == 2'd1));
      chk($sformatf("v%0d_ins_valid", i), 32'(ins_valid), 32'(vecs[i].st == 2'd2));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_ins_data", i), ins_data, vecs[i].data);
      chk($sformatf("v%0d_ins_pc", i), 32'(ins_pc), 32'(vecs[i].ipc));
      chk($sformatf("v%0d_fetch_cnt", i), 32'(fetch_cnt), 32'(vecs[i].cnt));
    end
    redirect = 1'b0;

    // three wait states, decode stalls for five cycles
    ws = 3; run = 1'b1; ins_ready = 1'b0;
    tick();
    reqs = 1; guard = 0;
    while (state_o == 2'd1 && guard < 30) begin
      tick(); guard++;
      if (state_o == 2'd1) reqs++;
    end
    chk("ws3_req_cycles", 32'(reqs), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ins_valid", 32'(ins_valid), 32'd1);
      chk("stall_ins_data", ins_data, 32'h900);
      chk("stall_ins_pc", 32'(ins_pc), 32'h800);
      chk("stall_mem_req", 32'(mem_req), 32'd0);
      tick();
    end
    ins_ready = 1'b1; run = 1'b0;
    tick();
    chk("stall_accept_cnt", 32'(fetch_cnt), 32'd6);
    chk("stall_accept_state", 32'(state_o), 32'd0);

    // redirect two cycles before a delayed ack: acked word is dropped
    run = 1'b1; ins_ready = 1'b0;
    tick();
    chk("rdr_first_addr", 32'(mem_addr), 32'h801);
    tick();
    redirect = 1'b1; redirect_pc = 12'h200;
    tick();
    redirect = 1'b0; redirect_pc = 12'h000;
    chk("rdr_addr_stable", 32'(mem_addr), 32'h801);
    tick();
    chk("rdr_ack_cycle_addr", 32'(mem_addr), 32'h801);
    tick();
    chk("rdr_new_addr", 32'(mem_addr), 32'h200);
    chk("rdr_new_req", 32'(mem_req), 32'd1);
    guard = 0;
    while (!ins_valid && guard < 30) begin
      tick(); guard++;
    end
    chk("rdr_valid_seen", 32'(ins_valid), 32'd1);
    chk("rdr_ins_pc", 32'(ins_pc), 32'h200);
    chk("rdr_ins_data", ins_data, 32'h300);
    ins_ready = 1'b1; run = 1'b0;
    tick();
    chk("rdr_accept_cnt", 32'(fetch_cnt), 32'd7);

    // asynchronous reset mid-request
    run = 1'b1;
    tick();
    chk("areset_pre_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_mem_req", 32'(mem_req), 32'd0);
    chk("areset_state", 32'(state_o), 32'd0);
    chk("areset_cnt", 32'(fetch_cnt), 32'd0);
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("areset_idle", 32'(state_o), 32'd0);

    // memory never acks: timeout into sticky error
    ack_en = 1'b0; run = 1'b1;
    tick();
    chk("tmo_req_rise", 32'(mem_req), 32'd1);
    n = 0;
    while (!err && n < 40) begin
      tick(); n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_state", 32'(state_o), 32'd3);
    for (int i = 0; i < 6; i++) begin
      run = i[0]; redirect = 1'b1; redirect_pc = 12'(i * 17);
      ack_en = i[1];
      tick();
      chk("err_state", 32'(state_o), 32'd3);
      chk("err_flag", 32'(err), 32'd1);
      chk("err_mem_req", 32'(mem_req), 32'd0);
      chk("err_ins_valid", 32'(ins_valid), 32'd0);
    end
    redirect = 1'b0; run = 1'b0; ack_en = 1'b1; ws = 0;
    #2 reset = 1'b1;
    #1;
    chk("err_reset_flag", 32'(err), 32'd0);
    chk("err_reset_state", 32'(state_o), 32'd0);
    tick();
    reset = 1'b0;

    // RESET_PC=0xFFE: fetches wrap past 0xFFF
    chk("wrap_start_addr", 32'(mem_addr2), 32'hFFE);
    run2 = 1'b1;
    got = 0; guard = 0;
    while (got < 3 && guard < 30) begin
      tick(); guard++;
      if (ins_valid2) begin
        pcs[got] = ins_pc2;
        got++;
      end
    end
    run2 = 1'b0;
    chk("wrap_count", 32'(got), 32'd3);
    if (got == 3) begin
      chk("wrap_pc0", 32'(pcs[0]), 32'hFFE);
      chk("wrap_pc1", 32'(pcs[1]), 32'hFFF);
      chk("wrap_pc2", 32'(pcs[2]), 32'h000);
    end
    chk("wrap_err2", 32'(err2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer for the core's command memory. It owns the program counter and issues one read at a time to the 4096-word command memory over a req/ack handshake. Each returned word is held in a one-deep valid/ready buffer for the decode stage. It also handles branch redirects, run/stop and a fetch timeout, and exports the PC and a retired-fetch count for the HEX display logic.

## Interface
- ADDR_W, 12, PC and memory address width
- DATA_W, 32, instruction word width
- RESET_PC, 0, PC value after reset
- TIMEOUT, 15, max cycles in REQ without mem_ack before error (range 1..255)

- clk  in  1  clock, all state changes on posedge
- reset  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = fetching allowed
- redirect  in  1  single-cycle pulse: load redirect_pc, flush buffer
- redirect_pc  in  ADDR_W  new PC
- mem_req  out  1  read request, high exactly while state = REQ
- mem_addr  out  ADDR_W  read address, equals pc register
- mem_ack  in  1  read complete this cycle; mem_rdata valid
- mem_rdata  in  DATA_W  read data
- ins_valid  out  1  ins_data/ins_pc valid, high exactly while state = HOLD
- ins_ready  in  1  decode accepts
- ins_data  out  DATA_W  fetched instruction
- ins_pc  out  ADDR_W  address ins_data was fetched from
- fetch_cnt  out  16  accepted instructions, wraps 0xFFFF -> 0
- err  out  1  sticky fetch-timeout flag
- state_o  out  2  IDLE=0, REQ=1, HOLD=2, ERR=3

## Operation
- Internal registers: pc, state, pend (redirect pending), pend_pc, tmo counter (8 bit).
- **IDLE**:
  - redirect: pc <= redirect_pc.
  - run=1: go to REQ; tmo <= 0.
- **REQ** (mem_req=1, mem_addr=pc):
  - mem_ack=1 with no redirect this cycle and pend=0: ins_data <= mem_rdata, ins_pc <= pc, pc <= pc+1 (mod 2^ADDR_W), go to HOLD.
  - mem_ack=1 with redirect this cycle or pend=1: discard data, pc <= redirect_pc (redirect beats pend_pc), pend <= 0, tmo <= 0, stay REQ. This issues a new request at the new address.
  - mem_ack=0 with redirect: pend <= 1, pend_pc <= redirect_pc. A later redirect overwrites pend_pc. The outstanding request is not abandoned; mem_addr holds stable until ack.
  - mem_ack=0 with tmo = TIMEOUT-1: go to ERR. Otherwise tmo++.
  - run dropping in REQ does not abort the request.
- **HOLD** (ins_valid=1):
  - redirect: flush, pc <= redirect_pc, go to REQ if run else IDLE. fetch_cnt is unchanged even if ins_ready=1 in the same cycle.
  - ins_ready=1 with no redirect: fetch_cnt++, go to REQ if run else IDLE.
  - Otherwise hold all outputs stable.
- **ERR**: mem_req=0, ins_valid=0, err=1. All inputs are ignored; only reset exits.
- Entry into REQ from any state clears tmo.

## Timing
- Reset values:
  - state IDLE, pc/mem_addr = RESET_PC
  - mem_req 0, ins_valid 0
  - ins_data 0, ins_pc 0
  - fetch_cnt 0, err 0, pend 0, tmo 0
- All outputs are registered or decoded from the state register only, with no combinational path from inputs to outputs.
- A zero-wait memory acks in the same cycle mem_req is seen:
  - run set in cycle 0, IDLE: cycle 1 REQ (ack), cycle 2 HOLD (ready), cycle 3 REQ.
  - Sustained throughput is 1 instruction / 2 cycles.
- An ack with N wait cycles adds N cycles per instruction.
- Redirect to first new request:
  - From IDLE or HOLD: mem_req is high with the new address 1 cycle later.
  - From REQ: 1 cycle after the outstanding ack.
- Timeout: if mem_req rises at cycle 1 and no ack arrives, err and state ERR are visible at cycle 1+TIMEOUT.
- PC wrap: after fetching 0xFFF, pc = 0x000, with no flag.
- Asynchronous reset mid-REQ or mid-HOLD drops mem_req and ins_valid immediately. Any in-flight ack after reset release is ignored, since the block is in IDLE.

## Test plan
- Reset, run=1, zero-wait memory with mem[i]=i+0x100, ins_ready=1 -> ins_data 0x100, 0x101, 0x102 with ins_pc 0, 1, 2 on cycles 2, 4, 6; fetch_cnt=3 after cycle 6.
- Memory with 3 wait states, ins_ready held 0 for 5 cycles -> ins_valid and ins_data stay stable; one accept increments fetch_cnt by 1; mem_req stays 0 during HOLD.
- Redirect to 0x200 in REQ two cycles before a delayed ack -> acked word discarded (never ins_valid); next mem_addr=0x200; then ins_pc=0x200.
- Redirect to 0x050 in HOLD with ins_ready=1 the same cycle -> ins_valid low next cycle, fetch_cnt unchanged, mem_addr=0x050.
- RESET_PC=0xFFE, 3 fetches -> ins_pc 0xFFE, 0xFFF, 0x000.
- TIMEOUT=15, memory never acks -> err=1 and state_o=3 exactly 15 cycles after mem_req rises; redirect and run toggling ignored; reset clears err and returns to IDLE.
